// File: rtl/rtf65002_ifetch_ctrl.sv
// rtf65002_ifetch_ctrl
// Instruction-fetch controller: fetches 32-bit little-endian words over a
// simple cyc/ack bus into a circular byte queue and presents the eight bytes
// at the head of the queue to the decoder.
//
// Optional feature macro: RTF65002_FETCH_ERR_EN (bus error input plus a
// sticky fetch error flag). With the macro undefined, err_i and fetch_err_o
// do not exist.
//
// Ports
//   clk_i        system clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   flush_i      discard the queue and restart fetching at new_pc_i
//   new_pc_i     byte address of the next instruction (any alignment)
//   adv_i        decoder consumes the head instruction this cycle
//   inc_i        bytes consumed when adv_i is accepted (0..7)
//   cyc_o/adr_o  word fetch request and word-aligned address
//   ack_i/dat_i  fetch acknowledge and read data
//   err_i        bus error for the current access (macro only)
//   fetch_err_o  sticky fetch error flag (macro only)
//   ir_o         head bytes, byte 0 (opcode) in [7:0]
//   ir_valid_o   at least eight bytes held
//   pc_o         byte address of the head byte
//   level_o      number of bytes held
//
// state   | meaning
// S_IDLE  | no bus access outstanding
// S_FETCH | cyc_o high, waiting for ack_i
// S_DRAIN | flushed while an access was outstanding; data will be dropped
module rtf65002_ifetch_ctrl #(
    parameter int QBYTES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        adv_i,
    input  logic [3:0]  inc_i,
    output logic        cyc_o,
    output logic [31:0] adr_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
`ifdef RTF65002_FETCH_ERR_EN
    input  logic        err_i,
    output logic        fetch_err_o,
`endif
    output logic [63:0] ir_o,
    output logic        ir_valid_o,
    output logic [31:0] pc_o,
    output logic [4:0]  level_o
);

    localparam int PW = $clog2(QBYTES);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_cyc;
    logic [31:0]     r_adr;
    logic [31:0]     r_pc;
    logic [31:0]     r_fadr;
    logic [1:0]      r_skip;
    logic            r_loaded;
    logic [LW-1:0]   r_level;
    logic [PW-1:0]   r_head;
    logic [7:0]      r_q [QBYTES];

    logic            w_err;
    logic            w_ferr;
    logic            w_term;
    logic            w_take;
    logic            w_adv;
    logic            w_valid;
    logic            w_can_issue;
    logic [2:0]      w_nbytes;
    logic [63:0]     w_ir;

`ifdef RTF65002_FETCH_ERR_EN
    logic r_ferr;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_ferr <= 1'b0;
        else if (flush_i)
            r_ferr <= 1'b0;
        else if (r_state == S_FETCH && err_i)
            r_ferr <= 1'b1;
    end

    assign w_err       = err_i;
    assign w_ferr      = r_ferr;
    assign fetch_err_o = r_ferr;
`else
    assign w_err  = 1'b0;
    assign w_ferr = 1'b0;
`endif

    // Any bus response ends the outstanding access; only a clean ack in
    // FETCH that is not overridden by a flush delivers bytes.
    assign w_term   = (r_state != S_IDLE) && (ack_i || w_err);
    assign w_take   = (r_state == S_FETCH) && ack_i && !w_err && !flush_i;
    assign w_valid  = (r_level >= LW'(8));
    assign w_adv    = adv_i && w_valid && !flush_i;
    // The first word after a flush starts mid-word at the instruction byte.
    assign w_nbytes = 3'd4 - {1'b0, r_skip};

    // Issuing only with room for a whole word means an ack can never overflow
    // the queue; removals while the access is in flight only add room.
    assign w_can_issue = (r_state == S_IDLE) && r_loaded && !w_ferr && !flush_i &&
                         (r_level <= LW'(QBYTES - 4));

    always_comb begin
        w_ir = '0;
        for (int k = 0; k < 8; k++)
            w_ir[8*k +: 8] = r_q[r_head + PW'(k)];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cyc    <= 1'b0;
            r_adr    <= '0;
            r_pc     <= '0;
            r_fadr   <= '0;
            r_skip   <= '0;
            r_loaded <= 1'b0;
            r_level  <= '0;
            r_head   <= '0;
            for (int i = 0; i < QBYTES; i++)
                r_q[i] <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_can_issue) begin
                        r_state <= S_FETCH;
                        r_cyc   <= 1'b1;
                        r_adr   <= r_fadr;
                    end
                end
                S_FETCH: begin
                    if (w_term) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                    end else if (flush_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_term) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase

            if (flush_i) begin
                r_level  <= '0;
                r_pc     <= new_pc_i;
                r_fadr   <= {new_pc_i[31:2], 2'b00};
                r_skip   <= new_pc_i[1:0];
                r_loaded <= 1'b1;
            end else begin
                if (w_take) begin
                    // Tail slot comes from the pre-removal head and level.
                    for (int k = 0; k < 4; k++) begin
                        if (2'(k) >= r_skip)
                            r_q[r_head + r_level[PW-1:0] + PW'(k) - PW'(r_skip)] <= dat_i[8*k +: 8];
                    end
                    r_fadr <= r_fadr + 32'd4;
                    r_skip <= 2'd0;
                end
                if (w_adv) begin
                    r_head <= r_head + PW'(inc_i);
                    r_pc   <= r_pc + 32'(inc_i);
                end
                r_level <= r_level + (w_take ? LW'(w_nbytes) : '0) - (w_adv ? LW'(inc_i) : '0);
            end
        end
    end

    assign cyc_o      = r_cyc;
    assign adr_o      = r_adr;
    assign pc_o       = r_pc;
    assign ir_o       = w_ir;
    assign ir_valid_o = w_valid;
    assign level_o    = 5'(r_level);

endmodule

// File: doc/rtf65002_ifetch_ctrl.md
RTF65002_IFETCH_CTRL -- requirements
Module: rtf65002_ifetch_ctrl

Interface
REQ-001 SHALL have parameter QBYTES, default 16, meaning byte-queue depth (power of two, >=12).
REQ-002 SHALL have port clk_i  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port flush_i  in  1  discard queue, restart fetch at new_pc_i.
REQ-005 SHALL have port new_pc_i  in  32  byte address of next instruction (any alignment).
REQ-006 SHALL have port adv_i  in  1  decoder consumes head instruction this cycle.
REQ-007 SHALL have port inc_i  in  4  bytes consumed on adv_i (from PC-increment table, 0..7).
REQ-008 SHALL have ports cyc_o out 1, adr_o out 32, ack_i in 1, dat_i in 32: word fetch bus, little-endian.
REQ-009 SHALL have ports ir_o out 64 (head bytes, byte0 = opcode in [7:0]), ir_valid_o out 1, pc_o out 32 (head byte address), level_o out 5 (bytes held).

Function
REQ-010 SHALL implement states IDLE (no access), FETCH (cyc_o high, awaiting ack_i), DRAIN (stale access pending after flush).
REQ-011 SHALL issue a fetch (IDLE->FETCH) only when level_o <= QBYTES-4 and a start address is loaded; adr_o = fetch address with [1:0]=00.
REQ-012 SHALL, on ack_i in FETCH, append the word's valid bytes, advance fetch address by 4, return to IDLE; back-to-back fetch allowed next cycle.
REQ-013 SHALL, for the first word after flush, drop the low new_pc_i[1:0] bytes (append 4-new_pc_i[1:0] bytes).
REQ-014 SHALL assert ir_valid_o when level_o >= 8; ir_o bytes beyond level_o are don't-care.
REQ-015 SHALL, on adv_i with ir_valid_o, remove inc_i bytes and add inc_i to pc_o (mod 2^32); adv_i with inc_i=0 or ir_valid_o=0 changes nothing.
REQ-016 SHALL apply ack_i append and adv_i removal in the same cycle: level = level + appended - inc_i.
REQ-017 SHALL, on flush_i, set level_o=0, pc_o=new_pc_i, fetch address=new_pc_i&~3 next cycle; flush_i wins over simultaneous adv_i and ack_i data.
REQ-018 SHALL, if flush_i occurs in FETCH without ack_i, enter DRAIN: hold cyc_o/adr_o until ack_i, discard data, then IDLE; a further flush_i in DRAIN only updates the restart address.
REQ-019 SHALL never overflow: REQ-011 guarantees room for every acknowledged word.

Reset
REQ-020 SHALL on rst_i set state IDLE, cyc_o=0, adr_o=0, ir_valid_o=0, pc_o=0, level_o=0, ir_o=0, start address unloaded.
REQ-021 SHALL not fetch after reset until the first flush_i; rst_i mid-access drops cyc_o next cycle, ack_i then ignored.

Configuration
REQ-022 SHALL, with macro RTF65002_FETCH_ERR_EN defined, add ports err_i in 1 and fetch_err_o out 1 (reset 0).
REQ-023 SHALL, with the macro, treat err_i in FETCH like ack_i without appending data, set fetch_err_o sticky, suppress further fetches until flush_i (flush_i clears fetch_err_o).
REQ-024 SHALL, without the macro, omit err_i/fetch_err_o entirely; behaviour otherwise identical.

Verification
REQ-025 SHALL cover: reset, flush_i new_pc_i=0x1000, ack every cycle with 0x03020100,0x07060504 -> adr_o 0x1000,0x1004; ir_valid_o after 2nd ack; ir_o=0x0706050403020100.
REQ-026 SHALL cover: flush_i new_pc_i=0x2003 -> adr_o 0x2000; 1 byte appended; level_o=1; pc_o=0x2003.
REQ-027 SHALL cover: full queue (level_o=16), ack withheld -> cyc_o stays 0; adv_i inc_i=5 -> level_o=11, pc_o+5, fetch resumes after level_o<=12.
REQ-028 SHALL cover: same-cycle ack_i and adv_i inc_i=3 at level_o=10 -> level_o=11.
REQ-029 SHALL cover: flush_i new_pc_i=0x3000 during pending access to 0x1008 -> DRAIN, data discarded on ack, next adr_o=0x3000, level_o=0.
REQ-030 SHALL cover (RTF65002_FETCH_ERR_EN): err_i on fetch -> fetch_err_o=1, cyc_o stays 0; flush_i -> fetch_err_o=0, fetch restarts.
